// File: rtl/pwm_capture.sv
// PWM input capture: reports the period and high time of an external PWM signal in clock cycles,
// with a sticky stuck-input flag when no expected edge arrives within TIMEOUT cycles.
module pwm_capture #(
    parameter int WIDTH       = 28,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 50000000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ENABLE,
    input  logic             PWM_IN,
    output logic [WIDTH-1:0] PERIOD,
    output logic [WIDTH-1:0] DECODE,
    output logic             VALID,
    output logic             STUCK,
    output logic             LEVEL
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic [WIDTH-1:0]       r_cnt;
    logic [WIDTH-1:0]       r_hi;
    logic [WIDTH-1:0]       r_period;
    logic [WIDTH-1:0]       r_decode;
    logic                   r_valid;
    logic                   r_stuck;
    state_t                 r_state;

    state_t w_next;
    logic   w_s;
    logic   w_rise;
    logic   w_fall;
    logic   w_at_timeout;
    logic   w_capture;
    logic   w_latch_hi;
    logic   w_timeout;

    assign w_s          = r_sync[SYNC_STAGES-1];
    assign w_rise       = w_s & ~r_s_d;
    assign w_fall       = ~w_s & r_s_d;
    assign w_at_timeout = (r_cnt == TIMEOUT_W);

    // NOTE: every flop here is updated with <= so all of them sample pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], PWM_IN};
            r_s_d  <= w_s;
        end
    end

    // NOTE: defaults are assigned first so no path leaves a signal unassigned (no latches).
    always_comb begin
        w_next     = r_state;
        w_capture  = 1'b0;
        w_latch_hi = 1'b0;
        w_timeout  = 1'b0;
        if (!ENABLE) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        w_next = HIGH;
                    end else if (w_at_timeout) begin
                        w_timeout = 1'b1;
                    end
                end
                HIGH: begin
                    if (w_fall) begin
                        w_latch_hi = 1'b1;
                        w_next     = LOW;
                    end else if (!w_rise && w_at_timeout) begin
                        w_timeout = 1'b1;
                        w_next    = IDLE;
                    end
                end
                LOW: begin
                    if (w_rise) begin
                        w_capture = 1'b1;
                        w_next    = HIGH;
                    end else if (!w_fall && w_at_timeout) begin
                        w_timeout = 1'b1;
                        w_next    = IDLE;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // The closing rise of one period is also the opening rise of the next, so cnt restarts at 1.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_period <= '0;
            r_decode <= '0;
            r_valid  <= 1'b0;
            r_stuck  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= w_capture;
            if (!ENABLE) begin
                r_cnt <= '0;
            end else if (w_rise) begin
                r_cnt <= WIDTH'(1);
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + WIDTH'(1);
            end
            if (w_latch_hi) begin
                r_hi <= r_cnt;
            end
            if (w_capture) begin
                r_period <= r_cnt;
                r_decode <= r_hi;
                r_stuck  <= 1'b0;
            end else if (w_timeout) begin
                r_period <= '0;
                r_decode <= '0;
                r_stuck  <= 1'b1;
            end
        end
    end

    assign PERIOD = r_period;
    assign DECODE = r_decode;
    assign VALID  = r_valid;
    assign STUCK  = r_stuck;
    assign LEVEL  = w_s;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: three instances with different TIMEOUT share one stimulus; a timestamp
// model predicts every output each cycle, and directed literal checks pin the model.
module tb_pwm_capture;

    localparam int W     = 28;
    localparam int SYNC  = 2;
    localparam int NINST = 3;
    localparam int TO_0  = 5000;
    localparam int TO_1  = 100;
    localparam int TO_2  = 10;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic enable = 1'b1;
    logic pwm_in = 1'b0;

    logic [W-1:0] period [NINST];
    logic [W-1:0] decode [NINST];
    logic         valid  [NINST];
    logic         stuck  [NINST];
    logic         level  [NINST];

    pwm_capture #(.WIDTH(W), .SYNC_STAGES(SYNC), .TIMEOUT(TO_0)) u0 (
        .CLK(clk), .RST_N(rst_n), .ENABLE(enable), .PWM_IN(pwm_in),
        .PERIOD(period[0]), .DECODE(decode[0]), .VALID(valid[0]), .STUCK(stuck[0]), .LEVEL(level[0])
    );
    pwm_capture #(.WIDTH(W), .SYNC_STAGES(SYNC), .TIMEOUT(TO_1)) u1 (
        .CLK(clk), .RST_N(rst_n), .ENABLE(enable), .PWM_IN(pwm_in),
        .PERIOD(period[1]), .DECODE(decode[1]), .VALID(valid[1]), .STUCK(stuck[1]), .LEVEL(level[1])
    );
    pwm_capture #(.WIDTH(W), .SYNC_STAGES(SYNC), .TIMEOUT(TO_2)) u2 (
        .CLK(clk), .RST_N(rst_n), .ENABLE(enable), .PWM_IN(pwm_in),
        .PERIOD(period[2]), .DECODE(decode[2]), .VALID(valid[2]), .STUCK(stuck[2]), .LEVEL(level[2])
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int vcnt [NINST];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: measurement phase per instance, with elapsed cycles taken from the timestamp of the
    // last counter restart rather than from a counter.
    typedef enum int {M_IDLE, M_HIGH, M_LOW} mphase_t;
    int       to_of [NINST] = '{TO_0, TO_1, TO_2};
    int       cyc = 0;
    logic     hist [0:SYNC] = '{default: 1'b0};
    mphase_t  ph      [NINST];
    int       t_start [NINST];
    logic [W-1:0] m_hi [NINST];
    logic [W-1:0] m_per [NINST];
    logic [W-1:0] m_dec [NINST];
    logic     m_val [NINST];
    logic     m_stk [NINST];
    logic     m_lvl = 1'b0;

    always @(posedge clk) begin
        logic s, sd, rise, fall;
        int   el;
        s    = hist[SYNC-1];
        sd   = hist[SYNC];
        rise = s & !sd;
        fall = !s & sd;
        for (int i = 0; i < NINST; i++) begin
            el = cyc - t_start[i];
            m_val[i] = 1'b0;
            if (!rst_n) begin
                ph[i] = M_IDLE; t_start[i] = cyc + 1; m_hi[i] = '0;
                m_per[i] = '0; m_dec[i] = '0; m_stk[i] = 1'b0;
            end else if (!enable) begin
                ph[i] = M_IDLE; t_start[i] = cyc + 1;
            end else begin
                case (ph[i])
                    M_IDLE: begin
                        if (rise) ph[i] = M_HIGH;
                        else if (el == to_of[i]) begin
                            m_per[i] = '0; m_dec[i] = '0; m_stk[i] = 1'b1;
                        end
                    end
                    M_HIGH: begin
                        if (fall) begin m_hi[i] = W'(el); ph[i] = M_LOW; end
                        else if (!rise && el == to_of[i]) begin
                            m_per[i] = '0; m_dec[i] = '0; m_stk[i] = 1'b1; ph[i] = M_IDLE;
                        end
                    end
                    default: begin
                        if (rise) begin
                            m_per[i] = W'(el); m_dec[i] = m_hi[i]; m_val[i] = 1'b1;
                            m_stk[i] = 1'b0; ph[i] = M_HIGH;
                        end else if (!fall && el == to_of[i]) begin
                            m_per[i] = '0; m_dec[i] = '0; m_stk[i] = 1'b1; ph[i] = M_IDLE;
                        end
                    end
                endcase
                if (rise) t_start[i] = cyc;
            end
        end
        for (int j = SYNC; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = pwm_in;
        if (!rst_n) for (int j = 0; j <= SYNC; j++) hist[j] = 1'b0;
        m_lvl = hist[SYNC-1];
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NINST; i++) begin
                check($sformatf("u%0d.period", i), period[i], m_per[i]);
                check($sformatf("u%0d.decode", i), decode[i], m_dec[i]);
                check($sformatf("u%0d.valid", i), W'(valid[i]), W'(m_val[i]));
                check($sformatf("u%0d.stuck", i), W'(stuck[i]), W'(m_stk[i]));
                check($sformatf("u%0d.level", i), W'(level[i]), W'(m_lvl));
                if (valid[i] === 1'b1) vcnt[i]++;
            end
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int p, input int h, input int n);
        repeat (n) begin
            pwm_in = 1'b1;
            wait_neg(h);
            pwm_in = 1'b0;
            wait_neg(p - h);
        end
    endtask

    task automatic clr_vcnt();
        for (int i = 0; i < NINST; i++) vcnt[i] = 0;
    endtask

    initial begin
        clr_vcnt();
        wait_neg(3);
        chk_en = 1'b1;
        check("reset.period", period[0], 0);
        check("reset.stuck", W'(stuck[0]), 0);
        rst_n = 1'b1;

        // Basic measurement: first rise only arms.
        clr_vcnt();
        drive(10, 3, 5);
        check("t1.vcount", W'(vcnt[0]), 4);
        check("t1.period", period[0], 10);
        check("t1.decode", decode[0], 3);
        check("t1.stuck", W'(stuck[0]), 0);
        check("t1.collide.period", period[2], 10);

        // Fastest waveform, then a slow near-100% waveform.
        drive(2, 1, 10);
        check("t2.fast.period", period[0], 2);
        check("t2.fast.decode", decode[0], 1);
        drive(1000, 999, 4);
        check("t2.slow.period", period[0], 1000);
        check("t2.slow.decode", decode[0], 999);
        check("t2.u1.stuck", W'(stuck[1]), 1);

        // Stuck-high timeout and recovery.
        drive(10, 5, 4);
        check("t3.pre.period", period[1], 10);
        pwm_in = 1'b1;
        wait_neg(150);
        check("t3.stuck", W'(stuck[1]), 1);
        check("t3.period0", period[1], 0);
        check("t3.decode0", decode[1], 0);
        check("t3.level", W'(level[1]), 1);
        check("t3.u0.hold", period[0], 10);
        drive(10, 5, 4);
        check("t3.recover.period", period[1], 10);
        check("t3.recover.decode", decode[1], 5);
        check("t3.recover.stuck", W'(stuck[1]), 0);

        // Enable dropped while in HIGH: outputs hold, no VALID.
        drive(10, 3, 2);
        pwm_in = 1'b1;
        wait_neg(3);
        pwm_in = 1'b0;
        wait_neg(1);
        enable = 1'b0;
        clr_vcnt();
        wait_neg(6);
        drive(10, 3, 2);
        check("t4.off.vcount", W'(vcnt[0]), 0);
        check("t4.off.period", period[0], 10);
        check("t4.off.decode", decode[0], 3);
        enable = 1'b1;
        clr_vcnt();
        drive(10, 3, 3);
        check("t4.on.vcount", W'(vcnt[0]), 2);

        // One-cycle reset in the LOW phase.
        pwm_in = 1'b1;
        wait_neg(3);
        pwm_in = 1'b0;
        wait_neg(3);
        rst_n = 1'b0;
        wait_neg(1);
        check("t5.period", period[0], 0);
        check("t5.decode", decode[0], 0);
        check("t5.stuck", W'(stuck[0]), 0);
        check("t5.level", W'(level[0]), 0);
        rst_n = 1'b1;
        wait_neg(4);
        clr_vcnt();
        drive(10, 3, 3);
        check("t5.vcount", W'(vcnt[0]), 2);
        check("t5.period.after", period[0], 10);

        // Rise coincides with the timeout count: the edge wins.
        drive(10, 5, 4);
        check("t6.period", period[2], 10);
        check("t6.decode", decode[2], 5);
        check("t6.stuck", W'(stuck[2]), 0);

        wait_neg(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
